// File: rtl/rom_fetch_arbiter_if.sv
// rom_fetch_arbiter_if: single-word ROM read channel between the fetch arbiter and the SDRAM/BRAM bridge
interface rom_fetch_arbiter_if #(parameter int ADDR_W = 24);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_data;
  modport master (output mem_req, mem_addr, input mem_ack, mem_data);
  modport slave (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares one ROM read channel between the M68K program ROM and the Z80 sound ROM
// Z80_HIT_CACHE_EN: optional one-word Z80 tag register that serves same-word re-reads without a fetch
module rom_fetch_arbiter #(
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] Z80_BASE = 'h040000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m68k_rom_cs,
  input  logic [23:1] m68k_a,
  output logic [15:0] m68k_rom_dout,
  output logic        m68k_rom_valid,
  input  logic        z80_rom_cs,
  input  logic [15:0] z80_addr,
  output logic [7:0]  z80_rom_dout,
  output logic        z80_wait_n,
  rom_fetch_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE, M_WAIT, Z_WAIT} state_t;
  state_t state, state_nx;
  logic        m_cs_q, z_cs_q, m_pend, z_pend, m_stale, z_stale, m_done, z_done, last_z, z_valid;
  logic [23:1] m_a_q;
  logic [15:1] z_a_q;
  logic        m_set, z_set, m_bad, z_bad, grant_m, grant_z, ack_m, ack_z, z_hit;
  logic [7:0]  hit_byte;
  assign m_set = m68k_rom_cs & (!m_cs_q | m68k_a != m_a_q);
  assign z_set = z80_rom_cs & (!z_cs_q | z80_addr[15:1] != z_a_q);
  // a request is superseded by a new address or by its select dropping
  assign m_bad = m_set | !m68k_rom_cs;
  assign z_bad = z_set | !z80_rom_cs;
  assign ack_m = state == M_WAIT & mem.mem_ack;
  assign ack_z = state == Z_WAIT & mem.mem_ack;
  assign mem.mem_req = state != IDLE;
  assign z80_wait_n = !(z80_rom_cs & !z_valid);
  always_comb begin
    state_nx = state;
    grant_m = 1'b0;
    grant_z = 1'b0;
    if (state == IDLE) begin
      grant_m = m_pend & (!z_pend | last_z);
      grant_z = z_pend & !grant_m;
      state_nx = grant_m ? M_WAIT : grant_z ? Z_WAIT : IDLE;
    end else if (mem.mem_ack) state_nx = IDLE;
  end
`ifdef Z80_HIT_CACHE_EN
  logic        tag_v;
  logic [15:1] tag_a, z_req;
  logic [15:0] tag_d;
  assign z_hit = z_set & tag_v & tag_a == z80_addr[15:1];
  assign hit_byte = z80_addr[0] ? tag_d[15:8] : tag_d[7:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tag_v <= 1'b0;
      tag_a <= '0;
      tag_d <= '0;
      z_req <= '0;
    end else begin
      if (grant_z) z_req <= z80_addr[15:1];
      if (ack_z) begin
        tag_v <= 1'b1;
        tag_a <= z_req;
        tag_d <= mem.mem_data;
      end
    end
`else
  assign z_hit = 1'b0;
  assign hit_byte = 8'h00;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_cs_q <= 1'b0;
      z_cs_q <= 1'b0;
      m_a_q <= '0;
      z_a_q <= '0;
      m_pend <= 1'b0;
      z_pend <= 1'b0;
      m_stale <= 1'b0;
      z_stale <= 1'b0;
      m_done <= 1'b0;
      z_done <= 1'b0;
      m68k_rom_valid <= 1'b0;
      z_valid <= 1'b0;
      m68k_rom_dout <= '0;
      z80_rom_dout <= '0;
      last_z <= 1'b1;
      mem.mem_addr <= '0;
    end else begin
      m_cs_q <= m68k_rom_cs;
      z_cs_q <= z80_rom_cs;
      m_a_q <= m68k_a;
      z_a_q <= z80_addr[15:1];
      m_pend <= m_set | (m_pend & !grant_m);
      z_pend <= (z_set & !z_hit) | (z_pend & !grant_z & !z_hit);
      m_stale <= grant_m ? 1'b0 : m_stale | m_bad;
      z_stale <= grant_z ? 1'b0 : z_stale | z_bad;
      m_done <= ack_m & !(m_stale | m_bad);
      z_done <= ack_z & !(z_stale | z_bad);
      if (ack_m & !(m_stale | m_bad)) m68k_rom_dout <= mem.mem_data;
      if (z_hit) z80_rom_dout <= hit_byte;
      else if (ack_z & !(z_stale | z_bad)) z80_rom_dout <= z80_addr[0] ? mem.mem_data[15:8] : mem.mem_data[7:0];
      m68k_rom_valid <= !m_bad & (m_done | m68k_rom_valid);
      z_valid <= z_hit | (!z_bad & (z_done | z_valid));
      if (ack_m | ack_z) last_z <= ack_z;
      if (grant_m) mem.mem_addr <= ADDR_W'({m68k_a, 1'b0});
      else if (grant_z) mem.mem_addr <= Z80_BASE + ADDR_W'({z80_addr[15:1], 1'b0});
    end
endmodule
